mult_shift_add_radix: RTL
=========================

Name: mult_shift_add_radix

Overview:
- Parametrised sequential multiplier for the Poly1305 datapath.
- Computes the full unsigned product of A_W-bit by B_W-bit operands.
- Consumes DIGIT_W bits of the multiplier per cycle, trading area against latency.
- Uses a start/busy/done handshake, adds a synchronous abort, and holds its result until the next completion.

Parameters:
- A_W, 130, multiplicand width (Poly1305 accumulator width).
- B_W, 128, multiplier width (clamped r width).
- DIGIT_W, 2, multiplier bits consumed per cycle. Must divide B_W; allowed values 1, 2, 4, 8.
- P_W, A_W+B_W, product width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a new multiply. Accepted only when busy=0.
- abort  in  1  synchronous cancel of the operation in flight
- a_in  in  A_W  multiplicand, sampled on accept
- b_in  in  B_W  multiplier, sampled on accept
- product_out  out  P_W  last completed product, held until next done
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, product_out valid

Behaviour:
- Reset values: product_out=0, busy=0, done=0. All internal registers (acc, a_shift, b_reg, digit count) are 0.
- Reset asserted mid-operation: operation is discarded immediately. No done is issued.
- Accept condition: start=1 and busy=0 at a rising edge. On that edge:
  - a_shift <= zero-extended a_in
  - b_reg <= b_in
  - acc <= 0
  - cnt <= 0
  - busy <= 1
- start while busy=1 is ignored. Operands are not resampled.
- Each busy edge:
  - pp = a_shift * b_reg[DIGIT_W-1:0], computed at P_W width.
  - acc <= acc + pp
  - a_shift <= a_shift << DIGIT_W
  - b_reg <= b_reg >> DIGIT_W
  - cnt <= cnt+1
- All arithmetic is modulo 2^P_W. The true product always fits, so there is no overflow.
- Final digit is on the edge where cnt == N-1, with N = B_W/DIGIT_W. On that edge:
  - product_out <= acc + pp (the final partial product is included)
  - busy <= 0
  - done <= 1
- Latency: accept at edge k gives done=1 and a valid product_out after edge k+N. Busy is high for exactly N cycles.
- done deasserts on the following edge regardless of inputs.
- Back-to-back: start=1 in the done cycle is accepted at the next edge. The gap between done and the next busy is zero cycles.
- abort=1 while busy at an edge:
  - busy <= 0, no done.
  - product_out keeps its previous value.
  - abort has priority over final-digit completion in the same cycle.
  - abort while idle has no effect. Simultaneous start and abort while idle: start wins.
- Counter width: clog2(N)+1. It wraps only via the accept reload.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: completion also occurs on any busy edge where the shifted b_reg (after this cycle's shift) is zero. product_out <= acc+pp and done pulses. Latency is ceil(msb_index(b_in)+1 / DIGIT_W) cycles, minimum 1 (b_in=0 gives product 0 after 1 busy cycle). Results are identical to fixed latency.
- Not defined: fixed N-cycle latency for all operands. This is the constant-time mode and the default for crypto use.

Decomposition:
- Shared package/include mult_pkg:
  - default widths A_W_POLY=130, B_W_POLY=128
  - allowed DIGIT_W list
  - N and counter-width computation helper (clog2)
- Sub-module mult_digit_pp: combinational A_W x DIGIT_W partial-product generator, P_W output. It is shift-and-add of up to DIGIT_W shifted copies, so the multiplier tree stays out of the FSM.
- Top level holds the idle/busy control, registers and accumulator.

Test Plan:
- a=2^130-1, b=2^128-1, DIGIT_W=2 -> product_out = 2^258 - 2^130 - 2^128 + 1; done exactly 64 cycles after accept; busy high 64 cycles.
- a=5, b=3 -> product_out=15. Without MULT_EARLY_EXIT_EN, done at cycle 64. With it, done at cycle 1. Repeat with b=0: product 0, latency 64 or 1 respectively.
- Accept a=7, b=9; pulse start with a=1, b=1 at busy cycle 20 -> ignored; product_out=63 at cycle 64.
- abort at busy cycle 10 -> busy=0 next cycle; no done; product_out retains the prior result. A following start with a=3, b=4 returns 12.
- reset asserted at busy cycle 30 -> busy, done, product_out all 0 immediately. A new operation after release completes correctly.
- Random sweep over DIGIT_W in {1,2,4,8} with back-to-back starts held high -> each product matches a reference multiply; no idle bubble beyond the done cycle.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add radix multiplier.
// Default Poly1305 operand widths, the supported digit widths, the FSM
// state type and helpers for the digit count and counter width.
package mult_pkg;

    localparam int A_W_POLY = 130;
    localparam int B_W_POLY = 128;

    // Digit widths the datapath supports. Each must also divide B_W.
    localparam int DIGIT_W_ALLOWED [4] = '{1, 2, 4, 8};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mult_state_e;

    // Number of busy cycles needed to consume the whole multiplier.
    function automatic int calc_n(input int b_w, input int digit_w);
        return b_w / digit_w;
    endfunction

    // One extra bit so the count never wraps while the operation is in flight.
    function automatic int calc_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // True when digit_w is supported and splits b_w into whole digits.
    function automatic bit digit_w_ok(input int b_w, input int digit_w);
        bit listed;
        listed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (DIGIT_W_ALLOWED[i] == digit_w) listed = 1'b1;
        end
        return listed && ((b_w % digit_w) == 0);
    endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Combinational partial-product generator: shifted multiplicand times one
// DIGIT_W-bit multiplier digit. Built as a sum of up to DIGIT_W shifted
// copies of the multiplicand so no general multiplier is inferred.
module mult_digit_pp
    import mult_pkg::*;
#(
    parameter int P_W     = A_W_POLY + B_W_POLY,
    parameter int DIGIT_W = 2
) (
    input  logic [P_W-1:0]     i_a,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [P_W-1:0]     o_pp
);

    // Add one shifted copy of the multiplicand per set bit of the digit.
    always_comb begin
        o_pp = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (i_digit[i]) o_pp = o_pp + (i_a << i);
        end
    end

endmodule

// File: rtl/mult_shift_add_radix.sv
// Sequential radix-2^DIGIT_W shift-and-add multiplier for Poly1305.
// Full unsigned A_W x B_W product, DIGIT_W multiplier bits per cycle,
// start/busy/done handshake with synchronous abort. The result is held on
// product_out until the next completion.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero. Undefined (default) gives constant-time
// operation with exactly B_W/DIGIT_W busy cycles for every operand.
// DIGIT_W must be one of 1, 2, 4, 8 and divide B_W (see mult_pkg::digit_w_ok).
module mult_shift_add_radix
    import mult_pkg::*;
#(
    parameter  int A_W     = A_W_POLY,
    parameter  int B_W     = B_W_POLY,
    parameter  int DIGIT_W = 2,
    localparam int P_W     = A_W + B_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W-1:0] b_in,
    output logic [P_W-1:0] product_out,
    output logic           busy,
    output logic           done
);

    localparam int N     = calc_n(B_W, DIGIT_W);
    localparam int CNT_W = calc_cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    mult_state_e      r_state;
    logic [P_W-1:0]   r_acc;
    logic [P_W-1:0]   r_a_shift;
    logic [B_W-1:0]   r_b_reg;
    logic [CNT_W-1:0] r_cnt;
    logic [P_W-1:0]   r_product;
    logic             r_busy;
    logic             r_done;

    logic [P_W-1:0]   w_pp;
    logic [P_W-1:0]   w_sum;
    logic [B_W-1:0]   w_b_next;
    logic             w_last;

    mult_digit_pp #(
        .P_W     (P_W),
        .DIGIT_W (DIGIT_W)
    ) u_digit_pp (
        .i_a     (r_a_shift),
        .i_digit (r_b_reg[DIGIT_W-1:0]),
        .o_pp    (w_pp)
    );

    assign w_sum    = r_acc + w_pp;
    assign w_b_next = r_b_reg >> DIGIT_W;

`ifdef MULT_EARLY_EXIT_EN
    // Nothing left to add once the remaining multiplier bits are zero.
    assign w_last = (r_cnt == CNT_LAST) || (w_b_next == '0);
`else
    assign w_last = (r_cnt == CNT_LAST);
`endif

    // Idle/busy control, operand shift registers, accumulator and result hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_a_shift <= '0;
            r_b_reg   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // abort is meaningless while idle, so start always wins here.
                    if (start) begin
                        r_a_shift <= P_W'(a_in);
                        r_b_reg   <= b_in;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // abort beats completion; the previous product stays visible.
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc     <= w_sum;
                        r_a_shift <= r_a_shift << DIGIT_W;
                        r_b_reg   <= w_b_next;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_product <= w_sum;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign product_out = r_product;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
